frame_buffer: RTL

FRAME_BUFFER -- requirements
Module: frame_buffer

---
 rtl/mem_config_pkg.sv | 16 +
 rtl/fb_ram.sv | 37 +++
 rtl/frame_buffer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_config_pkg.sv
// rtl/mem_config_pkg.sv - shared sizing defaults and FSM state encoding for the frame buffer
//
// Purpose: single place for the pixel/address width defaults and the fill/full
// state type used by frame_buffer.
// Ports: none (package).
package mem_config_pkg;

    localparam int FB_DATA_WIDTH = 8;
    localparam int FB_ADDR_WIDTH = 16;

    typedef enum logic [0:0] {
        FB_FILL = 1'b0,
        FB_FULL = 1'b1
    } fb_state_e;

endpackage

// File: rtl/fb_ram.sv
// rtl/fb_ram.sv - simple dual-port pixel RAM, one write port, one registered read port
//
// Purpose: frame storage. No reset so it maps onto block RAM; a read and a
// write to the same address in one cycle return the old contents.
// Ports:
//   clk_i      - clock
//   wr_en_i    - write strobe
//   wr_addr_i  - write address
//   wr_data_i  - write data
//   rd_en_i    - read strobe; rd_data_o only changes when this is high
//   rd_addr_i  - read address
//   rd_data_o  - registered read data
module fb_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - single-frame pixel buffer with fill/full handshake and pipelined reads
//
// Purpose: accepts one frame of NUM_PIXELS pixels, then holds it until the
// consumer releases it. Reads are accepted every cycle in either state.
// Ports:
//   clk_i, rst_i                - clock, synchronous active-high reset
//   wr_valid_i/wr_ready_o       - pixel write handshake, wr_data_i the pixel
//   frame_rel_i                 - consumer releases the held frame
//   frame_full_o                - a complete frame is held
//   fill_count_o                - pixels written into the current frame
//   rd_req_i/rd_addr_i          - read request and address
//   rd_valid_o/rd_data_o        - read result, 1+OUT_REG cycles after request
module frame_buffer
    import mem_config_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DATA_WIDTH,
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int NUM_PIXELS = 2**ADDR_WIDTH,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  frame_rel_i,
    output logic                  frame_full_o,
    output logic [ADDR_WIDTH:0]   fill_count_o,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(NUM_PIXELS - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(NUM_PIXELS);

    fb_state_e             state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   fill_cnt;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  rd_vld0;
    logic [DATA_WIDTH-1:0] ram_q;

    // Ready is withheld during reset so a producer never sees a handshake
    // that the buffer then drops.
    assign wr_ready_o   = (state == FB_FILL) && !rst_i;
    assign wr_fire      = wr_valid_i && wr_ready_o;
    // Reads in the reset cycle are dropped entirely; letting the RAM register
    // update would change rd_data_o while rd_valid_o stays low.
    assign rd_fire      = rd_req_i && !rst_i;
    assign frame_full_o = (state == FB_FULL);
    assign fill_count_o = fill_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= FB_FILL;
            wr_ptr   <= '0;
            fill_cnt <= '0;
        end else begin
            case (state)
                FB_FILL: begin
                    if (wr_fire) begin
                        if (wr_ptr == LAST_PTR) begin
                            wr_ptr   <= '0;
                            fill_cnt <= FULL_CNT;
                            state    <= FB_FULL;
                        end else begin
                            wr_ptr   <= wr_ptr + 1'b1;
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                FB_FULL: begin
                    if (frame_rel_i) begin
                        state    <= FB_FILL;
                        fill_cnt <= '0;
                    end
                end
                default: state <= FB_FILL;
            endcase
        end
    end

    fb_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (wr_fire),
        .wr_addr_i (wr_ptr),
        .wr_data_i (wr_data_i),
        .rd_en_i   (rd_fire),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (ram_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_vld0 <= 1'b0;
        end else begin
            rd_vld0 <= rd_fire;
        end
    end

    generate
        if (OUT_REG == 1) begin : g_out_reg
            logic                  rd_vld1;
            logic [DATA_WIDTH-1:0] out_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rd_vld1 <= 1'b0;
                end else begin
                    rd_vld1 <= rd_vld0;
                end
            end

            // Loads only alongside a valid so the output holds between results.
            always_ff @(posedge clk_i) begin
                if (rd_vld0 && !rst_i) begin
                    out_q <= ram_q;
                end
            end

            assign rd_valid_o = rd_vld1;
            assign rd_data_o  = out_q;
        end else begin : g_no_out_reg
            assign rd_valid_o = rd_vld0;
            assign rd_data_o  = ram_q;
        end
    endgenerate

endmodule
